// File: rtl/resp_sig_capture.sv
// resp_sig_capture: compresses a stream of wide DUT responses into a MISR
// signature and compares the final signature with an expected value.
// A run is armed with start, accepts n_samples responses (gaps allowed),
// then parks in DONE with the pass/fail verdict until the next start.
module resp_sig_capture #(
  parameter int unsigned      DATA_W = 550,
  parameter int unsigned      SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED   = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       n_samples,
  input  logic [SIG_W-1:0]  exp_sig,
  input  logic              y_valid,
  input  logic [DATA_W-1:0] y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  sig,
  output logic [15:0]       count
);

  // Number of SIG_W-bit chunks the response is cut into; the top chunk may
  // be partial and is zero-padded up to a full chunk.
  localparam int unsigned NCHUNK = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int unsigned PAD_W  = NCHUNK * SIG_W;

  // Every 2-bit code is named so the recovery path for the spare code is explicit.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_DONE    = 2'b10,
    ST_SPARE   = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [15:0]        count_q, count_d;
  logic               pass_q, pass_d;
  logic [15:0]        nSamples_q, nSamples_d;
  logic [SIG_W-1:0]   expSig_q, expSig_d;

  logic [PAD_W-1:0]   yPad;
  logic [SIG_W-1:0]   fold;
  logic [SIG_W-1:0]   sigStep;
  logic [15:0]        countInc;

  // Fold the wide response down to one signature word by XOR-ing its chunks.
  always_comb begin
    yPad              = '0;
    yPad[DATA_W-1:0]  = y;
    fold              = '0;
    for (int k = 0; k < int'(NCHUNK); k++) begin
      fold = fold ^ yPad[k*SIG_W +: SIG_W];
    end
  end

  // One MISR step: Galois-style shift with polynomial feedback, then inject the folded response.
  always_comb begin
    sigStep = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
  end

  // Next-state logic: run arming, sample acceptance and final verdict.
  always_comb begin
    state_d    = state_q;
    sig_d      = sig_q;
    count_d    = count_q;
    pass_d     = pass_q;
    nSamples_d = nSamples_q;
    expSig_d   = expSig_q;
    countInc   = count_q + 16'd1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          nSamples_d = n_samples;
          expSig_d   = exp_sig;
          sig_d      = SEED;
          count_d    = '0;
          if (n_samples == 16'd0) begin
            // An empty run finishes immediately and judges the untouched seed.
            state_d = ST_DONE;
            pass_d  = (SEED == exp_sig);
          end else begin
            state_d = ST_CAPTURE;
            pass_d  = 1'b0;
          end
        end
      end

      ST_CAPTURE: begin
        if (y_valid) begin
          sig_d   = sigStep;
          count_d = countInc;
          if (countInc == nSamples_q) begin
            state_d = ST_DONE;
            pass_d  = (sigStep == expSig_q);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        sig_d   = SEED;
        count_d = '0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset parks the block idle with a fresh seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sig_q      <= SEED;
      count_q    <= '0;
      pass_q     <= 1'b0;
      nSamples_q <= '0;
      expSig_q   <= '0;
    end else begin
      state_q    <= state_d;
      sig_q      <= sig_d;
      count_q    <= count_d;
      pass_q     <= pass_d;
      nSamples_q <= nSamples_d;
      expSig_q   <= expSig_d;
    end
  end

  assign busy  = (state_q == ST_CAPTURE);
  assign done  = (state_q == ST_DONE);
  assign pass  = pass_q & done;
  assign sig   = sig_q;
  assign count = count_q;

endmodule

// File: tb/tb_resp_sig_capture.sv
// tb_resp_sig_capture: randomized self-checking bench for resp_sig_capture.
// A behavioural model (bitwise fold, arithmetic MISR step, run bookkeeping)
// predicts every output each cycle; directed runs pin it to known values.
module tb_resp_sig_capture;

  localparam int unsigned      DATA_W = 550;
  localparam int unsigned      SIG_W  = 32;
  localparam logic [SIG_W-1:0] POLY   = 32'h04C11DB7;
  localparam logic [SIG_W-1:0] SEED   = 32'hFFFFFFFF;

  localparam int M_IDLE = 0;
  localparam int M_CAP  = 1;
  localparam int M_DONE = 2;

  logic              clk;
  logic              rst;
  logic              start;
  logic [15:0]       n_samples;
  logic [SIG_W-1:0]  exp_sig;
  logic              y_valid;
  logic [DATA_W-1:0] y;
  logic              busy;
  logic              done;
  logic              pass;
  logic [SIG_W-1:0]  sig;
  logic [15:0]       count;

  int vectors    = 0;
  int miscompares = 0;
  bit checkEn    = 1'b0;

  int               mMode;
  logic [SIG_W-1:0] mSig;
  logic [15:0]      mCount;
  logic             mPass;
  logic [15:0]      mN;
  logic [SIG_W-1:0] mExp;

  logic [DATA_W-1:0] stimQ[$];

  resp_sig_capture #(
    .DATA_W(DATA_W),
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n_samples(n_samples),
    .exp_sig  (exp_sig),
    .y_valid  (y_valid),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .sig      (sig),
    .count    (count)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit i of the response lands on signature bit (i mod SIG_W).
  function automatic logic [SIG_W-1:0] refFold(input logic [DATA_W-1:0] v);
    logic [SIG_W-1:0] f;
    f = '0;
    for (int i = 0; i < int'(DATA_W); i++) f[i % SIG_W] = f[i % SIG_W] ^ v[i];
    return f;
  endfunction

  // Multiply-by-x modulo the polynomial, then add the folded response.
  function automatic logic [SIG_W-1:0] refStep(input logic [SIG_W-1:0] s, input logic [DATA_W-1:0] v);
    logic [SIG_W-1:0] r;
    r = s << 1;
    if (s[SIG_W-1]) r = r ^ POLY;
    return r ^ refFold(v);
  endfunction

  function automatic logic [DATA_W-1:0] randVec();
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < int'((DATA_W + 31) / 32); i++) v = {v[DATA_W-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model of the run: what a capture run must look like after each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mMode  = M_IDLE;
      mSig   = SEED;
      mCount = '0;
      mPass  = 1'b0;
    end else if (mMode == M_CAP) begin
      if (y_valid) begin
        mSig   = refStep(mSig, y);
        mCount = mCount + 16'd1;
        if (mCount == mN) begin
          mMode = M_DONE;
          mPass = (mSig == mExp);
        end
      end
    end else if (start) begin
      mN     = n_samples;
      mExp   = exp_sig;
      mSig   = SEED;
      mCount = '0;
      if (n_samples == 16'd0) begin
        mMode = M_DONE;
        mPass = (SEED == exp_sig);
      end else begin
        mMode = M_CAP;
        mPass = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy",  32'(busy),  32'(mMode == M_CAP));
      checkOutput("done",  32'(done),  32'(mMode == M_DONE));
      checkOutput("sig",   32'(sig),   32'(mSig));
      checkOutput("count", 32'(count), 32'(mCount));
      if (mMode == M_DONE) checkOutput("pass", 32'(pass), 32'(mPass));
    end
  end

  // Runs the queued responses as one capture with random gaps and noise on
  // the ignored inputs, then checks the final state against a direct fold.
  task automatic applyStimulus(input bit releaseRst, input bit matchExp,
                               input logic [SIG_W-1:0] expOther, input bit holdStart,
                               input int maxGap);
    int n;
    logic [SIG_W-1:0] refSig;
    logic [SIG_W-1:0] expUsed;
    n      = stimQ.size();
    refSig = SEED;
    foreach (stimQ[i]) refSig = refStep(refSig, stimQ[i]);
    expUsed = matchExp ? refSig : expOther;

    @(negedge clk);
    if (releaseRst) rst = 1'b0;
    start     = 1'b1;
    n_samples = 16'(n);
    exp_sig   = expUsed;
    y_valid   = 1'b0;

    for (int i = 0; i < n; i++) begin
      int gaps;
      gaps = $urandom_range(0, maxGap);
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        start     = holdStart ? 1'b1 : 1'($urandom_range(0, 1));
        n_samples = 16'($urandom);
        exp_sig   = 32'($urandom);
        y_valid   = 1'b0;
        y         = randVec();
      end
      @(negedge clk);
      start     = holdStart ? 1'b1 : 1'($urandom_range(0, 1));
      n_samples = 16'($urandom);
      exp_sig   = 32'($urandom);
      y_valid   = 1'b1;
      y         = stimQ[i];
    end

    @(negedge clk);
    start   = 1'b0;
    y_valid = 1'b0;
    y       = randVec();
    checkOutput("run_done",  32'(done),  32'd1);
    checkOutput("run_busy",  32'(busy),  32'd0);
    checkOutput("run_count", 32'(count), 32'(n));
    checkOutput("run_sig",   32'(sig),   32'(refSig));
    checkOutput("run_pass",  32'(pass),  32'(refSig == expUsed));
    stimQ.delete();
  endtask

  // Wiggles y_valid while no run is active; nothing may change.
  task automatic idleToggle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      start   = 1'b0;
      y_valid = ~y_valid;
      y       = randVec();
    end
    @(negedge clk);
    y_valid = 1'b0;
  endtask

  initial begin
    logic [SIG_W-1:0] holdSig;
    rst       = 1'b1;
    start     = 1'b0;
    n_samples = '0;
    exp_sig   = '0;
    y_valid   = 1'b0;
    y         = '0;

    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset_busy",  32'(busy),  32'd0);
    checkOutput("reset_done",  32'(done),  32'd0);
    checkOutput("reset_pass",  32'(pass),  32'd0);
    checkOutput("reset_sig",   32'(sig),   32'hFFFFFFFF);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("model_pin",   32'(refStep(SEED, '0)), 32'hFB3EE249);

    // Empty run started on the very first edge after reset release.
    applyStimulus(1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 0);
    checkOutput("empty_done", 32'(done),  32'd1);
    checkOutput("empty_pass", 32'(pass),  32'd1);
    checkOutput("empty_sig",  32'(sig),   32'hFFFFFFFF);
    checkOutput("empty_cnt",  32'(count), 32'd0);

    // Single zero response, matching and non-matching expectation.
    stimQ.push_back('0);
    applyStimulus(1'b0, 1'b0, 32'hFB3EE249, 1'b0, 0);
    checkOutput("one_sig",  32'(sig),   32'hFB3EE249);
    checkOutput("one_pass", 32'(pass),  32'd1);
    checkOutput("one_cnt",  32'(count), 32'd1);
    stimQ.push_back('0);
    applyStimulus(1'b0, 1'b0, 32'h00000000, 1'b0, 0);
    checkOutput("one_fail_pass", 32'(pass), 32'd0);
    checkOutput("one_fail_sig",  32'(sig),  32'hFB3EE249);

    // DONE holds while y_valid wiggles.
    idleToggle(4);
    checkOutput("done_hold_sig", 32'(sig),  32'hFB3EE249);
    checkOutput("done_hold_cnt", 32'(count), 32'd1);

    // 21-response run with gaps, including all-ones and all-zero boundary vectors.
    for (int i = 0; i < 21; i++) begin
      if (i == 3)       stimQ.push_back('1);
      else if (i == 10) stimQ.push_back('0);
      else              stimQ.push_back(randVec());
    end
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 3);
    checkOutput("fuzz_cnt",  32'(count), 32'd21);
    checkOutput("fuzz_pass", 32'(pass),  32'd1);

    // start held high for the whole capture.
    for (int i = 0; i < 6; i++) stimQ.push_back(randVec());
    applyStimulus(1'b0, 1'b1, '0, 1'b1, 2);

    // Abort mid-run with a reset pulse that falls between clock edges.
    @(negedge clk);
    start     = 1'b1;
    n_samples = 16'd10;
    exp_sig   = 32'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start   = 1'b0;
      y_valid = 1'b1;
      y       = randVec();
    end
    @(negedge clk);
    y_valid = 1'b0;
    checkOutput("pre_abort_cnt", 32'(count), 32'd5);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy),  32'd0);
    checkOutput("abort_done", 32'(done),  32'd0);
    checkOutput("abort_sig",  32'(sig),   32'hFFFFFFFF);
    checkOutput("abort_cnt",  32'(count), 32'd0);
    idleToggle(5);
    checkOutput("idle_busy", 32'(busy),  32'd0);
    checkOutput("idle_sig",  32'(sig),   32'hFFFFFFFF);
    checkOutput("idle_cnt",  32'(count), 32'd0);

    // Clean run after the abort, then a batch of random runs.
    for (int i = 0; i < 4; i++) stimQ.push_back(randVec());
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1);
    for (int r = 0; r < 12; r++) begin
      int n;
      n = (r % 4 == 0) ? 0 : $urandom_range(1, 8);
      for (int i = 0; i < n; i++) stimQ.push_back(randVec());
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 32'($urandom), 1'b0, 2);
      holdSig = sig;
      idleToggle(2);
      checkOutput("rand_hold_sig", 32'(sig), 32'(holdSig));
    end

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
